// File: rtl/systolic_ctrl_pkg.sv
// rtl/systolic_ctrl_pkg.sv - shared widths and state encoding for the systolic array controller
package systolic_ctrl_pkg;

    localparam int PE_ACC_W = 32;
    localparam int ACT_W    = 9;
    localparam int WGT_W    = 8;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_CLEAR = 3'd1;
    localparam state_t ST_RUN   = 3'd2;
    localparam state_t ST_DRAIN = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

endpackage

// File: rtl/systolic_ctrl_skew_line.sv
// rtl/systolic_ctrl_skew_line.sv - per-lane operand delay chain feeding one edge of the PE array
module skew_line
    import systolic_ctrl_pkg::*;
#(
    parameter int DEPTH = 1,
    parameter int W     = ACT_W
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         advance,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_pass
            // Lane 0 has no skew: the operand goes straight to the first PE.
            logic unused_ctrl;
            assign unused_ctrl = ^{clk, clear, advance};
            assign dout = din;
        end else begin : g_chain
            logic [W-1:0] stage [DEPTH];

            // Shift only when the array advances so the lane stays aligned with the PEs.
            always_ff @(posedge clk) begin
                if (clear) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage[i] <= '0;
                    end
                end else if (advance) begin
                    stage[0] <= din;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign dout = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/systolic_ctrl.sv
// rtl/systolic_ctrl.sv - per-job sequencer: clear, feed, flush and drain the output-stationary PE array
module systolic_ctrl
    import systolic_ctrl_pkg::*;
#(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int K_W  = 9,
    localparam int NPE   = ROWS * COLS,
    localparam int IDX_W = (NPE > 1) ? $clog2(NPE) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [K_W-1:0]            k_len,
    output logic                      busy,
    output logic                      done,
    output logic                      buf_rd_en,
    output logic [K_W-1:0]            buf_rd_addr,
    output logic                      pe_clear,
    output logic                      pe_in_valid,
    output logic                      feed_zero,
    input  logic [NPE*PE_ACC_W-1:0]   pe_data,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [IDX_W-1:0]          res_idx,
    output logic [PE_ACC_W-1:0]       res_data
);

    // One extra counter bit so k_len plus the skew tail never wraps.
    localparam int CNT_W = K_W + 1;
    localparam logic [CNT_W-1:0] SKEW_TAIL = CNT_W'(ROWS + COLS - 2);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NPE - 1);

    state_t           state;
    logic [K_W-1:0]   k_reg;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] k_ext;
    logic [CNT_W-1:0] run_last;
    logic             in_run;
    logic             in_drain;

    assign k_ext    = {1'b0, k_reg};
    assign run_last = k_ext + SKEW_TAIL;
    assign in_run   = (state == ST_RUN);
    assign in_drain = (state == ST_DRAIN);

    // Job sequencing: one job in flight, k_len captured only when a job is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            k_reg   <= '0;
            cnt     <= '0;
            res_idx <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        k_reg <= k_len;
                        state <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    cnt   <= '0;
                    state <= ST_RUN;
                end
                ST_RUN: begin
                    if (cnt == run_last) begin
                        res_idx <= '0;
                        state   <= ST_DRAIN;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (res_ready) begin
                        if (res_idx == LAST_IDX) begin
                            res_idx <= '0;
                            state   <= ST_DONE;
                        end else begin
                            res_idx <= res_idx + IDX_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Status strobes decoded from the registered state.
    always_comb begin
        busy      = (state != ST_IDLE);
        done      = (state == ST_DONE);
        pe_clear  = (state == ST_CLEAR);
        res_valid = in_drain;
    end

    // Operand fetch and array advance: buffer data lands one cycle after the read,
    // so the array advances from the second RUN cycle and feeds zeros once reads run out.
    always_comb begin
        buf_rd_en   = in_run && (cnt < k_ext);
        buf_rd_addr = buf_rd_en ? cnt[K_W-1:0] : '0;
        pe_in_valid = in_run && (cnt != '0);
        feed_zero   = in_run && (cnt != '0) && ((cnt - CNT_W'(1)) >= k_ext);
    end

    // Result mux: accumulators are frozen during DRAIN, so the selected word holds across stalls.
    always_comb begin
        res_data = '0;
        for (int i = 0; i < NPE; i++) begin
            if (in_drain && (res_idx == IDX_W'(i))) begin
                res_data = pe_data[PE_ACC_W*i +: PE_ACC_W];
            end
        end
    end

endmodule

// File: tb/tb_systolic_ctrl.sv
// tb/tb_systolic_ctrl.sv - self-checking bench for systolic_ctrl with a small operand buffer and PE array
module tb_systolic_ctrl;

    localparam int ROWS  = 2;
    localparam int COLS  = 2;
    localparam int K_W   = 9;
    localparam int NPE   = ROWS * COLS;
    localparam int IDX_W = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic [K_W-1:0]       k_len = '0;
    logic                 res_ready = 1'b1;
    logic                 busy, done, buf_rd_en, pe_clear, pe_in_valid, feed_zero, res_valid;
    logic [K_W-1:0]       buf_rd_addr;
    logic [NPE*32-1:0]    pe_data;
    logic [IDX_W-1:0]     res_idx;
    logic [31:0]          res_data;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    systolic_ctrl #(.ROWS(ROWS), .COLS(COLS), .K_W(K_W)) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len),
        .busy(busy), .done(done), .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr),
        .pe_clear(pe_clear), .pe_in_valid(pe_in_valid), .feed_zero(feed_zero),
        .pe_data(pe_data), .res_valid(res_valid), .res_ready(res_ready),
        .res_idx(res_idx), .res_data(res_data)
    );

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- environment: operand buffers and a PE array ----------------
    int act_mem [16][ROWS];
    int wgt_mem [16][COLS];
    logic [8:0] rd_act [ROWS];
    logic [7:0] rd_wgt [COLS];
    logic [8:0] a_mux  [ROWS];
    logic [7:0] w_mux  [COLS];
    logic [8:0] a_sk   [ROWS];
    logic [7:0] w_sk   [COLS];
    logic [8:0] act_h  [ROWS][COLS];
    logic [7:0] wgt_v  [ROWS][COLS];
    int         acc    [ROWS][COLS];

    always @(posedge clk) begin
        if (buf_rd_en) begin
            for (int r = 0; r < ROWS; r++) rd_act[r] <= 9'(act_mem[buf_rd_addr[3:0]][r]);
            for (int c = 0; c < COLS; c++) rd_wgt[c] <= 8'(wgt_mem[buf_rd_addr[3:0]][c]);
        end
    end

    always_comb begin
        for (int r = 0; r < ROWS; r++) a_mux[r] = feed_zero ? 9'd0 : rd_act[r];
        for (int c = 0; c < COLS; c++) w_mux[c] = feed_zero ? 8'd0 : rd_wgt[c];
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_act
        skew_line #(.DEPTH(r), .W(9)) u_skew (
            .clk(clk), .clear(pe_clear), .advance(pe_in_valid), .din(a_mux[r]), .dout(a_sk[r]));
    end
    for (genvar c = 0; c < COLS; c++) begin : g_wgt
        skew_line #(.DEPTH(c), .W(8)) u_skew (
            .clk(clk), .clear(pe_clear), .advance(pe_in_valid), .din(w_mux[c]), .dout(w_sk[c]));
    end

    function automatic int pe_a(int r, int c);
        if (c == 0) return int'($signed(a_sk[r]));
        return int'($signed(act_h[r][c-1]));
    endfunction

    function automatic int pe_w(int r, int c);
        if (r == 0) return int'($signed(w_sk[c]));
        return int'($signed(wgt_v[r-1][c]));
    endfunction

    always @(posedge clk) begin
        if (pe_clear) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) begin
                    acc[r][c]   <= 0;
                    act_h[r][c] <= '0;
                    wgt_v[r][c] <= '0;
                end
        end else if (pe_in_valid) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) begin
                    acc[r][c]   <= acc[r][c] + pe_a(r, c) * pe_w(r, c);
                    act_h[r][c] <= 9'(pe_a(r, c));
                    wgt_v[r][c] <= 8'(pe_w(r, c));
                end
        end
    end

    always_comb begin
        pe_data = '0;
        for (int i = 0; i < NPE; i++) pe_data[32*i +: 32] = acc[i/COLS][i%COLS];
    end

    // ---------------- reference model: job timeline and plain matrix product ----------------
    function automatic int exp_val(int i, int k);
        int s = 0;
        for (int j = 0; j < k; j++) s += act_mem[j][i/COLS] * wgt_mem[j][i%COLS];
        return s;
    endfunction

    bit m_active = 1'b0;
    bit m_done   = 1'b0;
    int m_t      = 0;
    int m_k      = 0;
    int m_idx    = 0;
    int m_exp [NPE];
    bit stall_q  = 1'b0;
    logic [IDX_W-1:0] prev_idx;
    logic [31:0]      prev_data;

    function automatic int m_n();
        return m_k + ROWS + COLS - 1;
    endfunction
    function automatic bit m_run();
        return m_active && (m_t >= 2) && (m_t <= m_n() + 1);
    endfunction
    function automatic bit m_drain();
        return m_active && (m_t == m_n() + 2);
    endfunction
    function automatic int m_c();
        return m_t - 2;
    endfunction

    always @(posedge clk) begin
        stall_q <= res_valid && !res_ready;
        if (rst) begin
            m_active <= 1'b0;
            m_done   <= 1'b0;
            m_t      <= 0;
            m_idx    <= 0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (!m_active) begin
            if (start) begin
                m_active <= 1'b1;
                m_t      <= 1;
                m_k      <= int'(k_len);
                m_idx    <= 0;
                for (int i = 0; i < NPE; i++) m_exp[i] <= exp_val(i, int'(k_len));
            end
        end else if (m_t <= m_n() + 1) begin
            m_t <= m_t + 1;
        end else if (res_ready) begin
            if (m_idx == NPE - 1) begin
                m_active <= 1'b0;
                m_done   <= 1'b1;
            end else begin
                m_idx <= m_idx + 1;
            end
        end
    end

    // Every-cycle comparison of all controller outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", busy, m_active || m_done);
            check("done", done, m_done);
            check("pe_clear", pe_clear, m_active && m_t == 1);
            check("buf_rd_en", buf_rd_en, m_run() && m_c() < m_k);
            check("buf_rd_addr", buf_rd_addr, (m_run() && m_c() < m_k) ? m_c() : 0);
            check("pe_in_valid", pe_in_valid, m_run() && m_c() >= 1);
            check("feed_zero", feed_zero, m_run() && m_c() >= 1 && m_c() - 1 >= m_k);
            check("res_valid", res_valid, m_drain());
            check("res_idx", res_idx, m_drain() ? m_idx : 0);
            check("res_data", $signed(res_data), m_drain() ? m_exp[m_idx] : 0);
            if (stall_q) begin
                check("stall_hold_idx", res_idx, prev_idx);
                check("stall_hold_data", res_data, prev_data);
            end
        end
        prev_idx  <= res_idx;
        prev_data <= res_data;
    end

    // ---------------- directed stimulus ----------------
    int got [NPE];
    int acc_cnt [NPE];

    // mode 0: ready always high; 1: ready 1,0,0 repeating in DRAIN; 2: stray start pulses
    task automatic run_job(input int k, input int mode, output int clr_c, output int res_c,
                           output int done_c, output int rd_n, output int piv_n, output int fz_n);
        int dn;
        bit seen_done;
        clr_c = -1; res_c = -1; done_c = -1; rd_n = 0; piv_n = 0; fz_n = 0; dn = 0;
        seen_done = 1'b0;
        for (int j = 0; j < NPE; j++) begin got[j] = 0; acc_cnt[j] = 0; end
        @(negedge clk); #1;
        start = 1'b1;
        k_len = K_W'(k);
        for (int i = 1; i <= 200 && !seen_done; i++) begin
            @(negedge clk);
            if (pe_clear && clr_c < 0) clr_c = i;
            if (res_valid && res_c < 0) res_c = i;
            if (buf_rd_en) rd_n++;
            if (pe_in_valid) piv_n++;
            if (feed_zero) fz_n++;
            if (done) begin done_c = i; seen_done = 1'b1; end
            #1;
            start = 1'b0;
            if (mode == 2 && (i == 3 || (res_c > 0 && i == res_c + 1))) begin
                start = 1'b1;
                k_len = K_W'(7);
            end
            if (mode == 2 && done) begin
                start = 1'b1;
                k_len = K_W'(1);
            end
            if (mode == 1 && res_valid) begin
                res_ready = (dn % 3 == 0);
                dn++;
            end else begin
                res_ready = 1'b1;
            end
            if (res_valid && res_ready) begin
                acc_cnt[res_idx]++;
                got[res_idx] = $signed(res_data);
            end
        end
        if (!seen_done) check("job_timeout", 0, 1);
        @(negedge clk);
        if (mode == 2) check("start_in_done_ignored", busy, 0);
        #1;
        start = 1'b0;
        k_len = '0;
        res_ready = 1'b1;
        for (int j = 0; j < NPE; j++) check("accept_once", acc_cnt[j], 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int clr_c, res_c, done_c, rd_n, piv_n, fz_n, dn_seen;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_en", buf_rd_en, 0);
        check("rst_rd_addr", buf_rd_addr, 0);
        check("rst_clear", pe_clear, 0);
        check("rst_in_valid", pe_in_valid, 0);
        check("rst_feed_zero", feed_zero, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_idx", res_idx, 0);
        check("rst_res_data", res_data, 0);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;

        // Job 1: A=[[1,2,3],[-1,0,4]], W=[[2,1],[-3,5],[1,1]]
        act_mem[0] = '{1, -1}; act_mem[1] = '{2, 0}; act_mem[2] = '{3, 4};
        wgt_mem[0] = '{2, 1};  wgt_mem[1] = '{-3, 5}; wgt_mem[2] = '{1, 1};
        run_job(3, 0, clr_c, res_c, done_c, rd_n, piv_n, fz_n);
        check("j1_clear_cycle", clr_c, 1);
        check("j1_first_res_cycle", res_c, 8);
        check("j1_done_cycle", done_c, 12);
        check("j1_rd_cycles", rd_n, 3);
        check("j1_in_valid_cycles", piv_n, 5);
        check("j1_feed_zero_cycles", fz_n, 2);
        check("j1_res0", got[0], -1);
        check("j1_res1", got[1], 14);
        check("j1_res2", got[2], 2);
        check("j1_res3", got[3], 3);

        // Job 2: empty reduction
        run_job(0, 0, clr_c, res_c, done_c, rd_n, piv_n, fz_n);
        check("k0_done_cycle", done_c, 9);
        check("k0_rd_cycles", rd_n, 0);
        check("k0_in_valid_cycles", piv_n, 2);
        for (int j = 0; j < NPE; j++) check("k0_res_zero", got[j], 0);

        // Job 3: back-pressure on the result port
        act_mem[0] = '{5, -2}; act_mem[1] = '{-7, 3};
        wgt_mem[0] = '{4, -1}; wgt_mem[1] = '{2, 6};
        run_job(2, 1, clr_c, res_c, done_c, rd_n, piv_n, fz_n);
        check("stall_done_cycle", done_c, 17);
        check("stall_res0", got[0], 6);
        check("stall_res3", got[3], 20);

        // Job 4: stray start pulses and k_len changes while busy
        run_job(2, 2, clr_c, res_c, done_c, rd_n, piv_n, fz_n);
        check("stray_done_cycle", done_c, 11);
        check("stray_rd_cycles", rd_n, 2);
        for (int j = 0; j < NPE; j++) check("stray_res", got[j], exp_val(j, 2));

        // Job 5: reset in RUN at c=2, then a fresh job on the same operands
        for (int j = 0; j < 4; j++) begin
            act_mem[j] = '{int'($urandom_range(200)) - 100, int'($urandom_range(200)) - 100};
            wgt_mem[j] = '{int'($urandom_range(200)) - 100, int'($urandom_range(200)) - 100};
        end
        @(negedge clk); #1;
        start = 1'b1;
        k_len = K_W'(4);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 4) check("abort_at_c2_addr", buf_rd_addr, 2);
            #1;
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_rd_en", buf_rd_en, 0);
        check("abort_in_valid", pe_in_valid, 0);
        check("abort_feed_zero", feed_zero, 0);
        check("abort_res_valid", res_valid, 0);
        #1;
        rst = 1'b0;
        dn_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) dn_seen++;
        end
        check("abort_no_done", dn_seen, 0);
        run_job(4, 0, clr_c, res_c, done_c, rd_n, piv_n, fz_n);
        check("fresh_done_cycle", done_c, 13);
        for (int j = 0; j < NPE; j++) check("fresh_res", got[j], exp_val(j, 4));

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
